uart_tx_fifo: RTL

//   Synchronous FIFO that buffers bytes from the host/bus side and feeds the UART transmitter.
//   The write side accepts bytes from the host. The read side serves the TX engine through

---
 rtl/uart_tx_fifo.sv | 89 ++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO between the host write port and the UART transmitter.
// Output word is registered, non-show-ahead, and held until the next accepted pop.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int ADDR_BITS    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_C = (ADDR_BITS + 1)'(AFULL_THRESH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  // Flags come straight from the count register so they reflect the start of the cycle.
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = (count >= AFULL_C);

  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  // NOTE: storage has no reset; clearing the pointers and count is enough to discard data,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: every register here uses non-blocking assignments, so a pop from the slot being
  // written in the same cycle returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A new error in the same cycle as err_clr takes priority.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end

      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
